// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: opcodes, phase bounds,
// sequencer state encoding and default widths.
package phase_sequencer_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int OPCODE_WIDTH_DEF = 3;
  localparam int ADDR_WIDTH_DEF   = 5;
  localparam int ICNT_WIDTH_DEF   = 16;

  // VeriRisc opcodes
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Phase bounds: an instruction spans phases PHASE_FIRST..PHASE_LAST
  localparam logic [2:0] PHASE_FIRST = 3'd0;
  localparam logic [2:0] PHASE_LAST  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/phase_sequencer_ir_register.sv
// Instruction register: load-enabled DATA_WIDTH register split into the
// opcode (top bits) and address (bottom bits) fields.
module phase_sequencer_ir_register
  import phase_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0]   ir_addr
);

  logic [DATA_WIDTH-1:0] ir_r;

  // Capture the data bus when loading; reset value decodes as HLT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r <= '0;
    end else if (load) begin
      ir_r <= data_in;
    end else begin
      ir_r <= ir_r;
    end
  end

  assign opcode  = ir_r[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign ir_addr = ir_r[ADDR_WIDTH-1:0];

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: run/single-step control of the 3-bit instruction phase,
// instruction register, halt freeze and retired-instruction counter.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int ICNT_WIDTH   = ICNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    step,
  input  logic                    halt,
  input  logic                    ld_ir,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [2:0]              phase,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0]   ir_addr,
  output logic                    halted,
  output logic                    busy,
  output logic                    instr_done,
  output logic [ICNT_WIDTH-1:0]   icount
);

  state_e                state_r;
  state_e                state_next_s;
  logic [2:0]            phase_r;
  logic                  halted_r;
  logic                  busy_r;
  logic                  instr_done_r;
  logic [ICNT_WIDTH-1:0] icount_r;
  logic                  adv_s;
  logic                  wrap_s;
  logic                  ir_load_s;

  assign adv_s     = ((state_r == ST_RUN) || (state_r == ST_STEP)) && !halt;
  assign wrap_s    = adv_s && (phase_r == PHASE_LAST);
  // The IR is frozen once halted so the offending instruction stays visible
  assign ir_load_s = ld_ir && (state_r != ST_HALTED);

  // Next-state logic; halt takes priority over wrap and run/step changes
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_next_s = ST_RUN;
        end else if (step) begin
          state_next_s = ST_STEP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_next_s = ST_HALTED;
        end else if (wrap_s && !run) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_STEP: begin
        if (halt) begin
          state_next_s = ST_HALTED;
        end else if (wrap_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STEP;
        end
      end
      ST_HALTED: begin
        state_next_s = ST_HALTED;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register with status flags registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s == ST_RUN) || (state_next_s == ST_STEP);
      halted_r <= (state_next_s == ST_HALTED);
    end
  end

  // Phase counter, wrap pulse and retired-instruction count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r      <= PHASE_FIRST;
      instr_done_r <= 1'b0;
      icount_r     <= '0;
    end else begin
      phase_r      <= adv_s ? (phase_r + 3'd1) : phase_r;
      instr_done_r <= wrap_s;
      icount_r     <= icount_r + {{(ICNT_WIDTH-1){1'b0}}, wrap_s};
    end
  end

  phase_sequencer_ir_register #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_ir (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ir_load_s),
    .data_in (data_in),
    .opcode  (opcode),
    .ir_addr (ir_addr)
  );

  assign phase      = phase_r;
  assign halted     = halted_r;
  assign busy       = busy_r;
  assign instr_done = instr_done_r;
  assign icount     = icount_r;

endmodule
